// File: rtl/pattern_gen_pkg.sv
// Shared types and default sizing for the BRAM-driven GPIO pattern generator.
package pattern_gen_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_TS_W   = 26;
  localparam int DEF_LOOP_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PRIME = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4
  } pg_state_t;

endpackage

// File: rtl/pattern_gen_param_if.sv
// BRAM read port between the pattern generator (master) and the pattern memory (slave).
interface pattern_gen_param_if
  import pattern_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  // Read contract: no valid/ready; the memory always accepts bram_addr, and the word
  // for the address presented in cycle n is on bram_rd_data throughout cycle n+1.
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_rd_data;

  modport master (output bram_addr, input  bram_rd_data);
  modport slave  (input  bram_addr, output bram_rd_data);

endinterface

// File: rtl/pat_gen_timebase.sv
// Symbol-period divider: counts 0..period_m1 while enabled, tc on the last count.
module pat_gen_timebase #(
  parameter int TS_W = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [TS_W-1:0] period_m1,
  output logic            tc
);

  logic [TS_W-1:0] cnt;

  assign tc = en && (cnt == period_m1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + TS_W'(1);
    end
  end

endmodule

// File: rtl/pattern_gen_param.sv
// Plays BRAM words out on 2**lanes_log2 GPIO lanes, MSB-first, with looping and abort.
module pattern_gen_param
  import pattern_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TS_W   = DEF_TS_W,
  parameter int LOOP_W = DEF_LOOP_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic [ADDR_W-1:0]                    start_addr,
  input  logic [ADDR_W-1:0]                    end_addr,
  input  logic [$clog2($clog2(DATA_W)+1)-1:0]  lanes_log2,
  input  logic [TS_W-1:0]                      timestep_div,
  input  logic [LOOP_W-1:0]                    loop_count,
  input  logic [DATA_W-1:0]                    idle_level,
  pattern_gen_param_if.master                  bram,
  output logic [DATA_W-1:0]                    gpio_out,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 sym_strobe,
  output logic [LOOP_W-1:0]                    loops_done,
  output pg_state_t                            state_dbg
);

  localparam int LG_W = $clog2($clog2(DATA_W)+1);
  localparam int LMAX = $clog2(DATA_W);
  localparam int CW   = LMAX + 1;
  localparam logic [LG_W-1:0] LG_MAX = LG_W'(LMAX);

  pg_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, cur_q, sa_q, ea_q;
  logic [LG_W-1:0]   lg_q;
  logic [TS_W-1:0]   per_q;
  logic [LOOP_W-1:0] loop_q, loops_q, loops_inc;
  logic [DATA_W-1:0] idle_q, word_q, word_shift, gpio_q;
  logic [CW-1:0]     sym_q, lanes, nsym_m1;
  logic              done_q, strobe_q, tc, last_sym, cont;
  logic              accept, load_word, adv_sym, pass_end, finish;

  // Low L bits carry the top L bits of w; the remaining lanes rest at idle.
  function automatic logic [DATA_W-1:0] build_out(input logic [DATA_W-1:0] w,
                                                  input logic [CW-1:0]     l,
                                                  input logic [DATA_W-1:0] idle);
    logic [DATA_W-1:0] mask;
    mask = ~({DATA_W{1'b1}} << l);
    return ((w >> (CW'(DATA_W) - l)) & mask) | (idle & ~mask);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] s,
                                                  input logic [ADDR_W-1:0] e);
    return (a == e) ? s : a + ADDR_W'(1);
  endfunction

  assign lanes      = CW'(1) << lg_q;
  assign nsym_m1    = (CW'(DATA_W) >> lg_q) - CW'(1);
  assign last_sym   = (sym_q == nsym_m1);
  assign word_shift = word_q << lanes;

  pat_gen_timebase #(.TS_W(TS_W)) u_timebase (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q != PLAY),
    .en        (state_q == PLAY),
    .period_m1 (per_q),
    .tc        (tc)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_word = 1'b0;
    adv_sym   = 1'b0;
    pass_end  = 1'b0;
    finish    = 1'b0;
    loops_inc = (loops_q == '1) ? loops_q : loops_q + LOOP_W'(1);
    cont      = (loop_q == '0) || (loops_inc < loop_q);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FETCH;
          accept  = 1'b1;
        end
      end
      FETCH: state_d = PRIME;
      PRIME: begin
        state_d   = PLAY;
        load_word = 1'b1;
      end
      PLAY: begin
        if (tc) begin
          if (!last_sym) begin
            adv_sym = 1'b1;
          end else begin
            // The next word is already on bram_rd_data, so reloading here keeps output gapless.
            pass_end  = (cur_q == ea_q);
            finish    = pass_end && !cont;
            load_word = !finish;
            if (finish) state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d   = IDLE;
      accept    = 1'b0;
      load_word = 1'b0;
      adv_sym   = 1'b0;
      pass_end  = 1'b0;
      finish    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      cur_q    <= '0;
      sa_q     <= '0;
      ea_q     <= '0;
      lg_q     <= '0;
      per_q    <= '0;
      loop_q   <= '0;
      loops_q  <= '0;
      idle_q   <= '0;
      word_q   <= '0;
      gpio_q   <= '0;
      sym_q    <= '0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if ((state_q inside {IDLE, FETCH, DONE}) || stop) gpio_q <= idle_level;
      if (accept) begin
        sa_q    <= start_addr;
        ea_q    <= end_addr;
        lg_q    <= (lanes_log2 > LG_MAX) ? LG_MAX : lanes_log2;
        per_q   <= (timestep_div == '0) ? TS_W'(1) : timestep_div;
        loop_q  <= loop_count;
        idle_q  <= idle_level;
        loops_q <= '0;
        done_q  <= 1'b0;
        addr_q  <= start_addr;
      end
      if (load_word) begin
        word_q   <= bram.bram_rd_data;
        cur_q    <= addr_q;
        addr_q   <= next_addr(addr_q, sa_q, ea_q);
        sym_q    <= '0;
        gpio_q   <= build_out(bram.bram_rd_data, lanes, idle_q);
        strobe_q <= 1'b1;
      end
      if (adv_sym) begin
        word_q   <= word_shift;
        sym_q    <= sym_q + CW'(1);
        gpio_q   <= build_out(word_shift, lanes, idle_q);
        strobe_q <= 1'b1;
      end
      if (pass_end) loops_q <= loops_inc;
      if (finish) begin
        done_q <= 1'b1;
        gpio_q <= idle_level;
      end
    end
  end

  assign bram.bram_addr = addr_q;
  assign gpio_out       = gpio_q;
  assign busy           = state_q inside {FETCH, PRIME, PLAY};
  assign done           = done_q;
  assign sym_strobe     = strobe_q;
  assign loops_done     = loops_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_pattern_gen_param.sv
// Directed bench for pattern_gen_param: playback vector table plus stop/reset sequences.
module tb_pattern_gen_param;
  import pattern_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [12:0] start_addr = '0;
  logic [12:0] end_addr = '0;
  logic [1:0]  lanes_log2 = '0;
  logic [25:0] timestep_div = '0;
  logic [7:0]  loop_count = '0;
  logic [7:0]  idle_level = '0;
  logic [7:0]  gpio_out;
  logic        busy, done, sym_strobe;
  logic [7:0]  loops_done;
  pg_state_t   state_dbg;
  logic [12:0] bram_addr;

  logic [7:0]  mem [0:8191];
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [12:0] sa;
    logic [12:0] ea;
    logic [1:0]  lg;
    logic [25:0] div;
    logic [7:0]  loops;
    logic [7:0]  idle;
    bit          perturb;
    int          exp_nsym;
    int          exp_loops;
    int          exp_p;
  } vec_t;

  vec_t vecs [6];

  pattern_gen_param_if #(.DATA_W(8), .ADDR_W(13)) bus ();

  pattern_gen_param dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .lanes_log2   (lanes_log2),
    .timestep_div (timestep_div),
    .loop_count   (loop_count),
    .idle_level   (idle_level),
    .bram         (bus),
    .gpio_out     (gpio_out),
    .busy         (busy),
    .done         (done),
    .sym_strobe   (sym_strobe),
    .loops_done   (loops_done),
    .state_dbg    (state_dbg)
  );

  // Clock / memory model
  always #5 clk = ~clk;
  always @(posedge clk) bus.bram_rd_data <= mem[bus.bram_addr];
  assign bram_addr = bus.bram_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [12:0] sa, input logic [12:0] ea, input logic [1:0] lg,
                         input logic [25:0] dv, input logic [7:0] lp, input logic [7:0] idl);
    start_addr   = sa;
    end_addr     = ea;
    lanes_log2   = lg;
    timestep_div = dv;
    loop_count   = lp;
    idle_level   = idl;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0]  exp_q [$];
    logic [12:0] addr_exp [$];
    logic [12:0] addr_obs [$];
    logic [12:0] a;
    logic [7:0]  w, e;
    logic [15:0] bits0;
    int          l, c, last_t, nstrobe, nwords;
    bit          pass_over;
    // Expected symbol stream from the lane-mapping definition
    l = 1 << v.lg;
    for (int p = 0; p < int'(v.loops); p++) begin
      a = v.sa;
      pass_over = 0;
      while (!pass_over) begin
        w = mem[a];
        for (int k = 0; k < 8 / l; k++) begin
          e = v.idle;
          for (int i = 0; i < l; i++) e[i] = w[8 - l - k * l + i];
          exp_q.push_back(e);
        end
        if (a == v.ea) pass_over = 1;
        else a = a + 13'd1;
      end
    end
    nwords = exp_q.size() / (8 / l);
    a = v.sa;
    addr_exp.push_back(a);
    for (int n = 0; n < nwords; n++) begin
      a = (a == v.ea) ? v.sa : a + 13'd1;
      if (a != addr_exp[$]) addr_exp.push_back(a);
    end

    set_cfg(v.sa, v.ea, v.lg, v.div, v.loops, v.idle);
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    last_t = 0;
    nstrobe = 0;
    bits0 = '0;
    while (c < 3000) begin
      if (busy && (addr_obs.size() == 0 || bram_addr != addr_obs[$])) addr_obs.push_back(bram_addr);
      if (c == 1) check($sformatf("v%0d_fetch_busy", id), busy, 1);
      if (sym_strobe) begin
        check($sformatf("v%0d_strobe_time_%0d", id, nstrobe), c, (nstrobe == 0) ? 3 : last_t + v.exp_p);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL v%0d_extra_symbol: got %0h expected none", id, gpio_out);
        end else begin
          check($sformatf("v%0d_symbol_%0d", id, nstrobe), gpio_out, exp_q.pop_front());
        end
        bits0 = {bits0[14:0], gpio_out[0]};
        last_t = c;
        nstrobe++;
      end
      if (done) break;
      if (v.perturb) begin
        if (c == 5) set_cfg(13'd0, 13'd4, 2'd3, 26'd0, 8'd7, 8'h0F);
        if (c == 6) start = 1'b1;
        if (c == 7) start = 1'b0;
        if (c == 10) set_cfg(v.sa, v.ea, v.lg, v.div, v.loops, v.idle);
      end
      tick();
      c++;
    end
    check($sformatf("v%0d_done", id), done, 1);
    check($sformatf("v%0d_done_time", id), c, last_t + v.exp_p);
    check($sformatf("v%0d_busy_clear", id), busy, 0);
    check($sformatf("v%0d_idle_out", id), gpio_out, v.idle);
    check($sformatf("v%0d_loops_done", id), loops_done, v.exp_loops);
    check($sformatf("v%0d_nsym", id), nstrobe, v.exp_nsym);
    check($sformatf("v%0d_addr_count", id), addr_obs.size(), addr_exp.size());
    for (int i = 0; i < addr_exp.size() && i < addr_obs.size(); i++)
      check($sformatf("v%0d_addr_%0d", id, i), addr_obs[i], addr_exp[i]);
    if (id == 0) check("v0_lane0_bits", bits0, 16'hA53C);
  endtask

  // Infinite single-word loop, 2 clocks per pass, aborted with stop in cycle stop_at
  task automatic run_inf(input int stop_at, input logic [7:0] exp_ld);
    int c;
    set_cfg(13'd10, 13'd10, 2'd3, 26'd0, 8'd0, 8'h3C);
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (c < stop_at) begin
      tick();
      c++;
    end
    check($sformatf("inf%0d_busy", stop_at), busy, 1);
    check($sformatf("inf%0d_loops_pre", stop_at), loops_done, exp_ld);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check($sformatf("inf%0d_stop_busy", stop_at), busy, 0);
    check($sformatf("inf%0d_stop_gpio", stop_at), gpio_out, 8'h3C);
    check($sformatf("inf%0d_stop_done", stop_at), done, 0);
    check($sformatf("inf%0d_stop_loops", stop_at), loops_done, exp_ld);
    check($sformatf("inf%0d_stop_state", stop_at), state_dbg, IDLE);
    tick();
    check($sformatf("inf%0d_loops_held", stop_at), loops_done, exp_ld);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h11;  mem[1] = 8'h22;  mem[2] = 8'hA5;  mem[3] = 8'h3C;
    mem[4] = 8'h55;  mem[8] = 8'h96;  mem[9] = 8'h0F;  mem[10] = 8'h7E;
    mem[13'h1FFE] = 8'hDE;
    mem[13'h1FFF] = 8'hAD;

    //          sa        ea      lg    div     loops  idle   pert nsym lps P
    vecs[0] = '{13'd2,    13'd3,  2'd0, 26'd0,  8'd1,  8'h00, 0,   16,  1,  2};
    vecs[1] = '{13'd0,    13'd4,  2'd3, 26'd0,  8'd3,  8'h00, 0,   15,  3,  2};
    vecs[2] = '{13'h1FFE, 13'd1,  2'd3, 26'd1,  8'd1,  8'h00, 0,   4,   1,  2};
    vecs[3] = '{13'd8,    13'd9,  2'd1, 26'd3,  8'd2,  8'hC3, 0,   16,  2,  4};
    vecs[4] = '{13'd10,   13'd10, 2'd2, 26'd2,  8'd2,  8'h5A, 0,   4,   2,  3};
    vecs[5] = '{13'd2,    13'd3,  2'd0, 26'd4,  8'd1,  8'hF0, 1,   16,  1,  5};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_gpio", gpio_out, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobe", sym_strobe, 0);
    check("rst_loops", loops_done, 0);
    check("rst_state", state_dbg, IDLE);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    run_inf(100, 8'd48);
    run_inf(700, 8'd255);

    // start and stop together from IDLE
    idle_level = 8'h3C;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_state", state_dbg, IDLE);
    tick();
    tick();
    check("ss_busy_later", busy, 0);
    check("ss_gpio", gpio_out, 8'h3C);

    // reset in the middle of playback
    set_cfg(13'd10, 13'd10, 2'd2, 26'd5, 8'd0, 8'h5A);
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (c < 40) begin
      tick();
      c++;
    end
    check("mid_busy", busy, 1);
    check("mid_loops", loops_done, 3);
    check("mid_gpio", gpio_out, 8'h57);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_gpio", gpio_out, 0);
    check("mid_rst_addr", bram_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_strobe", sym_strobe, 0);
    check("mid_rst_loops", loops_done, 0);
    check("mid_rst_state", state_dbg, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_gen_param.md
PATTERN_GEN_PARAM -- requirements
Module: pattern_gen_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning BRAM word width and maximum lane count (power of 2, 2..32).
REQ-002 SHALL have parameter ADDR_W, default 13, meaning BRAM address width.
REQ-003 SHALL have parameter TS_W, default 26, meaning symbol-period divider width.
REQ-004 SHALL have parameter LOOP_W, default 8, meaning loop counter width.
REQ-005 Ports: clk  in  1  single clock; all logic on posedge.
REQ-006 Ports: rst  in  1  synchronous active-high reset.
REQ-007 Ports: start  in  1  start pulse.
REQ-008 Ports: stop  in  1  abort pulse.
REQ-009 Ports: start_addr, end_addr  in  ADDR_W  first and last word of the pattern.
REQ-010 Ports: lanes_log2  in  $clog2($clog2(DATA_W)+1)  active lane count L = 2**lanes_log2, legal values give L <= DATA_W.
REQ-011 Ports: timestep_div  in  TS_W  symbol period = max(timestep_div,1)+1 clocks.
REQ-012 Ports: loop_count  in  LOOP_W  number of passes; 0 means infinite.
REQ-013 Ports: idle_level  in  DATA_W  gpio value when not playing.
REQ-014 Ports: bram_rd_data  in  DATA_W  registered-read BRAM data, valid one cycle after address.
REQ-015 Ports: bram_addr  out  ADDR_W  BRAM read address.
REQ-016 Ports: gpio_out  out  DATA_W  registered pattern output.
REQ-017 Ports: busy, done, sym_strobe  out  1  status; loops_done  out  LOOP_W  completed passes.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, PRIME, PLAY, DONE.
REQ-019 IDLE/DONE + start (no stop) SHALL capture all config inputs into shadow registers, clear loops_done and done, and enter FETCH with bram_addr=start_addr.
REQ-020 Config input changes after capture SHALL NOT affect a running pattern.
REQ-021 FETCH SHALL last 1 cycle; PRIME SHALL load the word register from bram_rd_data, set bram_addr to the next address, and enter PLAY.
REQ-022 First symbol SHALL appear on gpio_out 3 cycles after the start cycle.
REQ-023 Symbol k of a word (k = 0..DATA_W/L-1) SHALL be word[DATA_W-1-k*L -: L], driven on gpio_out[L-1:0] with word MSB on gpio_out[L-1]; gpio_out[DATA_W-1:L] SHALL equal idle_level[DATA_W-1:L].
REQ-024 Each symbol SHALL hold for exactly max(timestep_div,1)+1 clocks; sym_strobe SHALL pulse 1 cycle on every gpio_out update.
REQ-025 On the last clock of the last symbol of a word, the word register SHALL load bram_rd_data, and bram_addr SHALL advance, giving gapless output.
REQ-026 Next address SHALL be start_addr after end_addr, otherwise addr+1 modulo 2**ADDR_W; end_addr < start_addr SHALL wrap through 0.
REQ-027 At end of the last symbol of end_addr, loops_done SHALL increment, saturating at all-ones.
REQ-028 At that point, if loop_count==0 or the incremented loops_done < loop_count, playback SHALL continue at start_addr without gap.
REQ-029 Otherwise the FSM SHALL enter DONE, gpio_out=idle_level the next cycle, busy=0, and done=1 held until the next accepted start.
REQ-030 busy SHALL be 1 in FETCH, PRIME and PLAY.
REQ-031 stop in any state SHALL enter IDLE next cycle with gpio_out=idle_level, busy=0, done unchanged, and loops_done held.
REQ-032 start while busy SHALL be ignored; start and stop in the same cycle: stop wins.

Reset
REQ-033 rst SHALL force IDLE: gpio_out=0, bram_addr=0, busy=0, done=0, sym_strobe=0, loops_done=0, all counters 0, regardless of state.

Structure
REQ-034 Package pattern_gen_pkg SHALL hold the state enum and the default parameter constants.
REQ-035 Symbol-period counting SHALL be a sub-module pat_gen_timebase (divider counter with terminal-count pulse, sync clear).

Verification
REQ-036 DATA_W=8, L=1, div=0, start=2, end=3, loop=1, words 0xA5,0x3C -> gpio_out[0] = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, each 2 clocks, first at start+3, then done=1.
REQ-037 L=8, div=0, start=0, end=4, loop=3 -> 15 gapless words, 2 clocks each, loops_done=3, done=1, bram_addr sequence wraps 4->0.
REQ-038 start=0x1FFE, end=0x0001, ADDR_W=13 -> addresses 1FFE,1FFF,0000,0001.
REQ-039 loop=0, stop after 100 cycles -> busy=0 and gpio_out=idle_level next cycle, done=0; start+stop same cycle -> stays IDLE.
REQ-040 rst mid-PLAY with L=4, div=5 -> all outputs 0 next cycle; config change mid-run -> output unaffected.
